// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch stage: next-PC commands, FSM states.
// Optional JAL link capture is enabled by defining JAL_LINK_EN.
package fetch_unit_pkg;

  localparam int DEFAULT_ADDR_W = 16;

  localparam logic [1:0] PC_HOLD   = 2'b00;
  localparam logic [1:0] PC_INC    = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  localparam logic [1:0] PC_BRANCH = 2'b11;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

endpackage

// File: rtl/fetch_unit_next_pc.sv
// Combinational next-PC select: hold, increment, jump or PC-relative branch.
// All sums wrap modulo 2^ADDR_W.
module next_pc_calc
  import fetch_unit_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic [1:0]        pcEn,
  input  logic [ADDR_W-1:0] target,
  input  logic [7:0]        disp,
  output logic [ADDR_W-1:0] pcInc,
  output logic [ADDR_W-1:0] nextPc
);

  logic [ADDR_W-1:0] dispExt;

  assign dispExt = {{(ADDR_W-8){disp[7]}}, disp};
  assign pcInc   = pc + ADDR_W'(1);

  always_comb begin
    nextPc = pc;
    unique case (1'b1)
      pcEn == PC_HOLD:   nextPc = pc;
      pcEn == PC_INC:    nextPc = pcInc;
      pcEn == PC_JUMP:   nextPc = target;
      pcEn == PC_BRANCH: nextPc = pc + dispExt;
      default:           nextPc = pc;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// PC + instruction register stage with req/ack instruction fetch.
// Define JAL_LINK_EN to add the linkAddr return-address register.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int                ADDR_W   = DEFAULT_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch,
  input  logic [1:0]        pcEn,
  input  logic              isJal,
  input  logic [15:0]       jumpTarget,
  output logic              memReq,
  output logic [ADDR_W-1:0] memAddr,
  input  logic              memAck,
  input  logic [15:0]       memData,
  output logic [15:0]       instruction,
  output logic              instrValid,
  output logic              busy,
  output logic [ADDR_W-1:0] pc
`ifdef JAL_LINK_EN
  ,
  output logic [ADDR_W-1:0] linkAddr
`endif
);

  state_t            state;
  state_t            nextState;
  logic [ADDR_W-1:0] pcInc;
  logic [ADDR_W-1:0] pcNext;
  logic              pcCmd;
  logic              ackd;

  next_pc_calc #(
    .ADDR_W(ADDR_W)
  ) u_next_pc (
    .pc    (pc),
    .pcEn  (pcEn),
    .target(jumpTarget[ADDR_W-1:0]),
    .disp  (instruction[7:0]),
    .pcInc (pcInc),
    .nextPc(pcNext)
  );

  assign pcCmd   = (state == IDLE) && (pcEn != PC_HOLD);
  assign ackd    = (state == REQ) && memAck;
  assign memReq  = (state == REQ);
  assign busy    = (state == REQ);
  assign memAddr = pc;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (fetch)  nextState = REQ;
      REQ:     if (memAck) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // pc only moves in IDLE, so memAddr is stable for the whole request
  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= RESET_PC;
      instruction <= '0;
      instrValid  <= 1'b0;
    end else begin
      if (pcCmd) begin
        pc         <= pcNext;
        instrValid <= 1'b0;
      end
      if (ackd) begin
        instruction <= memData;
        instrValid  <= 1'b1;
      end
    end
  end

`ifdef JAL_LINK_EN
  always_ff @(posedge clk) begin
    if (reset)
      linkAddr <= '0;
    else if (pcCmd && pcEn == PC_JUMP && isJal)
      linkAddr <= pcInc;
  end
`else
  logic unused_jal;
  assign unused_jal = isJal ^ (^pcInc);
`endif

endmodule
